// File: rtl/rrat_multi.sv
// Retirement register alias table with multi-slot commit.
// Displaced physical tags queue in a FIFO toward the free list.
module rrat_multi #(
  parameter int ARCH_REGS     = 32,
  parameter int PHYS_REG_BITS = 6,
  parameter int COMMIT_WIDTH  = 2,
  parameter int FREE_Q_DEPTH  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic [COMMIT_WIDTH*$clog2(ARCH_REGS)-1:0] commit_rd,
  input  logic [COMMIT_WIDTH*PHYS_REG_BITS-1:0] commit_pd,
  output logic commit_ready,
  output logic free_valid,
  output logic [PHYS_REG_BITS-1:0] free_pd,
  input  logic free_ready,
  output logic [$clog2(FREE_Q_DEPTH):0] free_count,
  output logic [ARCH_REGS*PHYS_REG_BITS-1:0] rrat_out
);

  localparam int AW = $clog2(ARCH_REGS);
  localparam int PB = PHYS_REG_BITS;
  localparam int QW = $clog2(FREE_Q_DEPTH);
  localparam int CW = QW + 1;

  logic [PB-1:0] map_q [ARCH_REGS];
  logic [PB-1:0] map_d [ARCH_REGS];

  logic [PB-1:0] fifo_q [FREE_Q_DEPTH];
  logic [QW-1:0] head_q;
  logic [QW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [COMMIT_WIDTH-1:0] acc;
  logic [COMMIT_WIDTH-1:0] slot_push;
  logic [PB-1:0] slot_tag [COMMIT_WIDTH];
  logic [QW-1:0] slot_off [COMMIT_WIDTH];
  logic [CW-1:0] push_cnt;
  logic pop;

  // Admission uses only registered occupancy; pops this cycle do not help.
  assign commit_ready =
    count_q <= CW'(FREE_Q_DEPTH - COMMIT_WIDTH);
  assign acc = commit_valid & {COMMIT_WIDTH{commit_ready}};

  assign free_valid = count_q != '0;
  assign free_pd    = fifo_q[head_q];
  assign free_count = count_q;
  assign pop        = free_valid & free_ready;

  // Walk slots oldest first so a later same-rd slot displaces the
  // earlier slot's tag rather than the stale table entry.
  always_comb begin
    logic [AW-1:0] rd;
    logic [PB-1:0] pd;
    logic [PB-1:0] old;
    logic [QW-1:0] off;
    rd  = '0;
    pd  = '0;
    old = '0;
    off = '0;
    map_d    = map_q;
    push_cnt = '0;
    slot_push = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_tag[k] = '0;
      slot_off[k] = '0;
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      rd = commit_rd[k*AW +: AW];
      pd = commit_pd[k*PB +: PB];
      if (acc[k] && rd != '0) begin
        old = map_d[rd];
        map_d[rd] = pd;
        if (old != '0) begin
          slot_push[k] = 1'b1;
          slot_tag[k]  = old;
          slot_off[k]  = off;
          off      = off + QW'(1);
          push_cnt = push_cnt + CW'(1);
        end
      end
    end
    map_d[0] = '0;
  end

  // Flatten the bypassed mapping onto the recovery port.
  always_comb begin
    rrat_out = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      rrat_out[i*PB +: PB] = map_d[i];
    end
  end

  // Committed mapping register; reset restores the identity map.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PB'(i);
      end
    end else begin
      map_q <= map_d;
    end
  end

  // FIFO storage; pushes land at tail plus their slot-order offset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (slot_push[k]) begin
          fifo_q[tail_q + slot_off[k]] <= slot_tag[k];
        end
      end
    end
  end

  // FIFO pointers and occupancy; reset discards same-cycle pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + QW'(push_cnt);
      head_q  <= head_q + QW'(pop);
      count_q <= count_q + push_cnt - CW'(pop);
    end
  end

endmodule

// File: tb/tb_rrat_multi.sv
// Directed plus randomized checks of rrat_multi against a
// queue-and-array reference model of the retirement table.
module tb_rrat_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] commit_valid;
  logic [9:0] commit_rd;
  logic [11:0] commit_pd;
  logic commit_ready;
  logic free_valid;
  logic [5:0] free_pd;
  logic free_ready;
  logic [3:0] free_count;
  logic [191:0] rrat_out;

  rrat_multi dut (
    .clk(clk),
    .rst(rst),
    .commit_valid(commit_valid),
    .commit_rd(commit_rd),
    .commit_pd(commit_pd),
    .commit_ready(commit_ready),
    .free_valid(free_valid),
    .free_pd(free_pd),
    .free_ready(free_ready),
    .free_count(free_count),
    .rrat_out(rrat_out)
  );

  int vectors = 0;
  int errs = 0;
  int mmap [32];
  int q [$];
  logic [191:0] last_rrat;
  logic [191:0] ident;

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmap[i] = i;
    q.delete();
  endtask

  // One clock: drive, check against the model mid-cycle, then advance.
  task automatic cyc(input bit v0, input int r0, input int p0,
                     input bit v1, input int r1, input int p1,
                     input bit fr, input bit rs);
    int nm [32];
    int pushes [$];
    int rd [2];
    int pd [2];
    bit acc [2];
    bit rdy;
    logic [191:0] exp_map;
    rst = rs;
    commit_valid = {v1, v0};
    commit_rd = {5'(r1), 5'(r0)};
    commit_pd = {6'(p1), 6'(p0)};
    free_ready = fr;
    #1;
    rdy = (8 - q.size()) >= 2;
    rd[0] = r0; rd[1] = r1;
    pd[0] = p0; pd[1] = p1;
    acc[0] = v0 && rdy;
    acc[1] = v1 && rdy;
    nm = mmap;
    for (int k = 0; k < 2; k++) begin
      if (acc[k] && rd[k] != 0) begin
        int old;
        old = mmap[rd[k]];
        for (int j = 0; j < k; j++)
          if (acc[j] && rd[j] == rd[k]) old = pd[j];
        if (old != 0) pushes.push_back(old);
      end
    end
    for (int k = 0; k < 2; k++)
      if (acc[k] && rd[k] != 0) nm[rd[k]] = pd[k];
    exp_map = '0;
    for (int i = 0; i < 32; i++) exp_map[i*6 +: 6] = 6'(nm[i]);
    if (!rs) begin
      chk("commit_ready", commit_ready, rdy);
      chk("free_valid", free_valid, q.size() != 0);
      chk("free_count", free_count, q.size());
      if (q.size() != 0) chk("free_pd", free_pd, q[0]);
      chk("rrat_out", rrat_out, exp_map);
    end
    last_rrat = rrat_out;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (q.size() != 0 && fr) void'(q.pop_front());
      foreach (pushes[i]) q.push_back(pushes[i]);
      mmap = nm;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit fr);
    cyc(0, 0, 0, 0, 0, 0, fr, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    commit_valid = '0;
    commit_rd = '0;
    commit_pd = '0;
    free_ready = 1'b0;
    ident = '0;
    for (int i = 0; i < 32; i++) ident[i*6 +: 6] = 6'(i);
    model_reset();
    do_reset();
    do_reset();

    // single commit, bypass, one-cycle push latency
    cyc(1, 5, 40, 0, 0, 0, 1, 0);
    chk("t1_map5", last_rrat[30 +: 6], 40);
    chk("t1_fv", free_valid, 1);
    chk("t1_fpd", free_pd, 5);
    idle(1);
    chk("t1_cnt", free_count, 0);

    // same rd in both slots
    cyc(1, 7, 33, 1, 7, 34, 0, 0);
    chk("t2_map7", last_rrat[42 +: 6], 34);
    chk("t2_cnt", free_count, 2);
    chk("t2_first", free_pd, 7);
    idle(1);
    chk("t2_second", free_pd, 33);
    idle(1);

    // rd 0 and zero old tag
    cyc(1, 0, 50, 0, 0, 0, 1, 0);
    chk("t3_map0", last_rrat[0 +: 6], 0);
    chk("t3_rd0_nopush", free_count, 0);
    cyc(1, 3, 0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(1, 3, 9, 0, 0, 0, 1, 0);
    chk("t3_zero_nopush", free_count, 0);

    // back-pressure
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 10 + 2*i, 40 + 2*i, 1, 11 + 2*i, 41 + 2*i, 0, 0);
    chk("t4_full", free_count, 8);
    chk("t4_ready0", commit_ready, 0);
    cyc(1, 20, 60, 1, 21, 61, 0, 0);
    chk("t4_nochange", last_rrat[120 +: 6], 20);
    idle(1);
    chk("t4_ready_at7", commit_ready, 0);
    idle(1);
    chk("t4_cnt6", free_count, 6);
    chk("t4_ready_at6", commit_ready, 1);
    repeat (6) idle(1);
    chk("t4_drained", free_count, 0);

    // wrap-around with toggling free_ready
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1, $urandom_range(1, 31), $urandom_range(1, 63),
          0, 0, 0, 1'(i % 2), 0);
    repeat (12) idle(1);
    chk("t5_drained", free_count, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      bit wide;
      wide = $urandom_range(0, 1) == 1;
      cyc(1'($urandom_range(0, 1)),
          wide ? $urandom_range(0, 31) : $urandom_range(0, 5),
          $urandom_range(0, 63),
          1'($urandom_range(0, 1)),
          wide ? $urandom_range(0, 31) : $urandom_range(0, 5),
          $urandom_range(0, 63),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0);
    end

    // reset mid-drain
    do_reset();
    cyc(1, 1, 41, 1, 2, 42, 0, 0);
    cyc(1, 3, 43, 1, 4, 44, 0, 0);
    cyc(1, 5, 45, 0, 0, 0, 0, 0);
    chk("t7_cnt5", free_count, 5);
    cyc(1, 6, 46, 1, 7, 47, 1, 1);
    chk("t7_fv", free_valid, 0);
    chk("t7_cnt", free_count, 0);
    chk("t7_ready", commit_ready, 1);
    rst = 1'b0;
    commit_valid = '0;
    #1;
    chk("t7_ident", rrat_out, ident);
    @(negedge clk);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
